// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder: align via an external mantissa shifter, add/sub,
// normalize one bit per cycle, truncate, and hand the result out over valid/ready.
module fp_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic [23:0] sh_a,
    output logic [7:0]  sh_sbits,
    input  logic [23:0] sh_o
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        inf;
        logic        nan;
    } fp_unp_t;

    // Exponent-zero inputs (zeros and subnormals) are flushed to a clean zero.
    function automatic fp_unp_t unpack(input logic [31:0] v);
        fp_unp_t u;
        u.s   = v[31];
        u.e   = v[30:23];
        u.m   = (v[30:23] != 8'd0) ? {1'b1, v[22:0]} : 24'd0;
        u.inf = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
        u.nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        return u;
    endfunction

    state_t      state, state_n;
    logic [31:0] ra, rb, ra_n, rb_n;
    logic [23:0] mx, mx_n, my_al, my_al_n;
    logic        sub, sub_n, s, s_n;
    logic [7:0]  e, e_n, e_inc;
    logic [24:0] m, m_n;
    logic [31:0] sum_n;

    fp_unp_t ua, ub, ux, uy;
    logic    a_ge;

    always_comb begin
        ua   = unpack(ra);
        ub   = unpack(rb);
        a_ge = {ua.e, ua.m} >= {ub.e, ub.m};
        ux   = a_ge ? ua : ub;
        uy   = a_ge ? ub : ua;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign e_inc     = e + 8'd1;

    always_comb begin
        state_n  = state;
        ra_n     = ra;
        rb_n     = rb;
        mx_n     = mx;
        my_al_n  = my_al;
        sub_n    = sub;
        s_n      = s;
        e_n      = e;
        m_n      = m;
        sum_n    = sum;
        sh_a     = 24'd0;
        sh_sbits = 8'd0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    ra_n    = a;
                    rb_n    = b;
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                sh_a     = uy.m;
                sh_sbits = ux.e - uy.e;
                my_al_n  = sh_o;
                mx_n     = ux.m;
                sub_n    = ux.s ^ uy.s;
                e_n      = ux.e;
                s_n      = ux.s;
                if (ua.e == 8'hFF || ub.e == 8'hFF) begin
                    state_n = DONE;
                    if (ua.nan || ub.nan || (ua.inf && ub.inf && (ua.s != ub.s)))
                        sum_n = 32'h7FC00000;
                    else
                        sum_n = {ua.inf ? ua.s : ub.s, 8'hFF, 23'd0};
                end else begin
                    state_n = ADD;
                end
            end
            ADD: begin
                // Ordering guarantees mx >= my_al, so the difference never wraps.
                m_n     = sub ? ({1'b0, mx} - {1'b0, my_al}) : ({1'b0, mx} + {1'b0, my_al});
                state_n = NORM;
            end
            NORM: begin
                if (m[24]) begin
                    sum_n   = (e_inc == 8'hFF) ? {s, 8'hFF, 23'd0} : {s, e_inc, m[23:1]};
                    state_n = DONE;
                end else if (m == 25'd0) begin
                    sum_n   = 32'd0;
                    state_n = DONE;
                end else if (m[23]) begin
                    sum_n   = {s, e, m[22:0]};
                    state_n = DONE;
                end else if (e == 8'd1) begin
                    sum_n   = {s, 31'd0};
                    state_n = DONE;
                end else begin
                    m_n = {m[23:0], 1'b0};
                    e_n = e - 8'd1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= 32'd0;
            rb    <= 32'd0;
            mx    <= 24'd0;
            my_al <= 24'd0;
            sub   <= 1'b0;
            s     <= 1'b0;
            e     <= 8'd0;
            m     <= 25'd0;
            sum   <= 32'd0;
        end else begin
            ra    <= ra_n;
            rb    <= rb_n;
            mx    <= mx_n;
            my_al <= my_al_n;
            sub   <= sub_n;
            s     <= s_n;
            e     <= e_n;
            m     <= m_n;
            sum   <= sum_n;
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed-vector bench for fp_add_seq with a behavioural model of the shared shifter.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_i, b_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic [23:0] sh_a;
    logic [7:0]  sh_sbits;
    logic [23:0] sh_o;

    int total = 0;
    int bad   = 0;
    logic [23:0] last_sa;
    logic [7:0]  last_ss;

    always #5 clk = ~clk;

    assign sh_o = (sh_sbits >= 8'd24) ? 24'd0 : (sh_a >> sh_sbits);

    fp_add_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
        .sh_a(sh_a), .sh_sbits(sh_sbits), .sh_o(sh_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE with out_ready=1; returns at a negedge back in IDLE.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp, input int lat);
        int   n;
        logic seen;
        a_i = av;
        b_i = bv;
        in_valid = 1'b1;
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                last_sa = sh_a;
                last_ss = sh_sbits;
            end
            if (n == 2)
                chk({tag, "_sh_quiet"}, {sh_sbits, sh_a}, 32'd0);
            if (out_valid) seen = 1'b1;
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_sum"}, sum, exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a_i = 32'd0;
        b_i = 32'd0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_sh", {sh_sbits, sh_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("eq_add",   32'h3F800000, 32'h3F800000, 32'h40000000, 4);
        run_op("align",    32'h3FC00000, 32'h3E800000, 32'h3FE00000, 4);
        chk("align_sha", {8'd0, last_sa}, 32'h00800000);
        chk("align_sbits", {24'd0, last_ss}, 32'd2);
        run_op("align_sw", 32'h3E800000, 32'h3FC00000, 32'h3FE00000, 4);
        chk("align_sw_sha", {8'd0, last_sa}, 32'h00800000);
        run_op("cancel_k2", 32'h3F800000, 32'hBF400000, 32'h3E800000, 6);
        run_op("exact_can", 32'h3F800000, 32'hBF800000, 32'h00000000, 4);
        run_op("neg_k1",   32'hBF800000, 32'h3F000000, 32'hBF000000, 5);
        run_op("big_shift", 32'h3F800000, 32'h30800000, 32'h3F800000, 4);
        chk("big_sbits", {24'd0, last_ss}, 32'd30);
        run_op("ovf_inf",  32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4);
        run_op("inf_nan",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 2);
        run_op("nan_in",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2);
        run_op("ninf",     32'h3F800000, 32'hFF800000, 32'hFF800000, 2);
        run_op("denorm",   32'h00400000, 32'h3F800000, 32'h3F800000, 4);
        run_op("uflow",    32'h80800001, 32'h00800000, 32'h80000000, 4);

        // Backpressure: hold the result, offer a second operand pair meanwhile.
        out_ready = 1'b0;
        a_i = 32'h3F800000;
        b_i = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_seen", {31'd0, seen}, 32'd1);
        a_i = 32'h3FC00000;
        b_i = 32'h3E800000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_busy", {31'd0, in_ready}, 32'd0);
            chk("bp_sum", sum, 32'h40000000);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_rdy", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", {31'd0, in_ready}, 32'd0);
        seen = 1'b0;
        n = 1;
        while (!seen && n < 64) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp2_seen", {31'd0, seen}, 32'd1);
        chk("bp2_lat", n, 32'd4);
        chk("bp2_sum", sum, 32'h3FE00000);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a long normalization (m=1 needs 23 left shifts).
        a_i = 32'h3F800000;
        b_i = 32'hBF7FFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
        end
        run_op("post_rst", 32'h3F800000, 32'h3F800000, 32'h40000000, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
